// File: rtl/bus_burst_pkg.sv
// Shared types and next-beat address helper for the burst engine.
// Burst kinds, FSM states, WRAP/INCR address stepping.
package bus_burst_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    INCR   = 2'b01,
    WRAP   = 2'b10,
    RSVD   = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BEAT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // WRAP keeps the upper bits and lets the low (len+1)*bytes window roll over
  function automatic logic [63:0] next_beat_addr(
    input logic [63:0]  cur,
    input burst_type_t  btype,
    input logic [7:0]   len,
    input int unsigned  bytes
  );
    logic [63:0] step;
    logic [63:0] mask;
    step = cur + 64'(bytes);
    mask = ((64'(len) + 64'd1) * 64'(bytes)) - 64'd1;
    if (btype == WRAP)
      return (cur & ~mask) | (step & mask);
    return step;
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Combinational next beat address for INCR / WRAP bursts.
// Standalone so the stepping rules can be exercised on their own.
module burst_addr_gen
  import bus_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur,
  input  burst_type_t           btype,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] nxt
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  assign nxt = ADDR_WIDTH'(next_beat_addr(64'(cur), btype, len, BYTES));

endmodule

// File: rtl/bus_burst_engine.sv
// Burst-to-single-beat engine for simple peripherals.
// Optional stall watchdog: define BURST_TIMEOUT_EN.
module bus_burst_engine
  import bus_burst_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_type,
  input  logic [7:0]              req_len,
  input  logic [DATA_WIDTH/8-1:0] req_strobe,
  input  logic                    wbeat_valid,
  input  logic [DATA_WIDTH-1:0]   wbeat_data,
  output logic                    wbeat_ready,
  output logic                    rbeat_valid,
  output logic [DATA_WIDTH-1:0]   rbeat_data,
  output logic                    rbeat_last,
  output logic                    done,
  output logic                    done_err,
  output logic                    done_timeout,
  output logic                    p_wen,
  output logic                    p_ren,
  output logic [ADDR_WIDTH-1:0]   p_addr,
  output logic [DATA_WIDTH-1:0]   p_wdata,
  output logic [DATA_WIDTH/8-1:0] p_strobe,
  input  logic [DATA_WIDTH-1:0]   p_rdata,
  input  logic                    p_error,
  input  logic                    p_request_stall
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam bit CFG_OK =
    (DATA_WIDTH == 8 || DATA_WIDTH == 16 ||
     DATA_WIDTH == 32 || DATA_WIDTH == 64) &&
    (TIMEOUT_CYCLES > 0);

  state_t                  state;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  burst_type_t             r_type;
  logic [7:0]              r_len;
  logic [BYTES-1:0]        r_strobe;
  logic [7:0]              beat_cnt;
  logic                    err;

  logic                    in_beat;
  logic                    beat_done;
  logic                    last;
  logic                    chk_err;
  logic                    timeout_hit;
  logic [ADDR_WIDTH-1:0]   nxt_addr;

  burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .cur   (r_addr),
    .btype (r_type),
    .len   (r_len),
    .nxt   (nxt_addr)
  );

  assign in_beat   = (state == BEAT);
  assign last      = (beat_cnt == r_len);
  assign beat_done = in_beat & ~p_request_stall &
                     (~r_write | wbeat_valid);

  assign chk_err =
    (r_type == RSVD) ||
    ((r_addr & ADDR_WIDTH'(BYTES - 1)) != '0) ||
    ((r_type == WRAP) &&
     !(r_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

  assign req_ready   = CFG_OK & (state == IDLE) & ~rst;
  assign wbeat_ready = in_beat & r_write & wbeat_valid &
                       ~p_request_stall;
  assign p_wen       = in_beat & r_write & wbeat_valid;
  assign p_ren       = in_beat & ~r_write;
  assign p_addr      = in_beat ? r_addr : '0;
  assign p_wdata     = p_wen ? wbeat_data : '0;
  assign p_strobe    = p_wen ? r_strobe : '0;
  assign done        = (state == RESP);
  assign done_err    = done & err;

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stall_cnt;
  logic          tout;

  assign timeout_hit = in_beat & p_request_stall &
                       (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  // run length of consecutive stalled cycles within BEAT
  always_ff @(posedge clk) begin
    if (rst || !(in_beat && p_request_stall))
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || state == IDLE)
      tout <= 1'b0;
    else if (timeout_hit)
      tout <= 1'b1;
  end

  assign done_timeout = done & tout;
`else
  assign timeout_hit  = 1'b0;
  assign done_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_type      <= SINGLE;
      r_len       <= '0;
      r_strobe    <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
      rbeat_valid <= 1'b0;
      rbeat_data  <= '0;
      rbeat_last  <= 1'b0;
    end else begin
      rbeat_valid <= beat_done & ~r_write;
      rbeat_last  <= beat_done & ~r_write & (last | p_error);
      if (beat_done && !r_write)
        rbeat_data <= p_rdata;

      unique case (state)
        IDLE: begin
          if (req_valid && CFG_OK) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_type   <= burst_type_t'(req_type);
            r_len    <= (req_type == SINGLE) ? 8'd0 : req_len;
            r_strobe <= req_strobe;
            beat_cnt <= '0;
            err      <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (chk_err) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            state <= BEAT;
          end
        end
        BEAT: begin
          if (timeout_hit) begin
            err   <= 1'b1;
            state <= RESP;
          end else if (beat_done) begin
            beat_cnt <= beat_cnt + 8'd1;
            r_addr   <= nxt_addr;
            if (p_error) begin
              err   <= 1'b1;
              state <= RESP;
            end else if (last) begin
              state <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_burst_engine.sv
// Directed bench for bus_burst_engine (default and BURST_TIMEOUT_EN builds).
module tb_bus_burst_engine;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef BURST_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_type;
  logic [7:0]    req_len;
  logic [3:0]    req_strobe;
  logic          wbeat_valid, wbeat_ready;
  logic [DW-1:0] wbeat_data;
  logic          rbeat_valid, rbeat_last;
  logic [DW-1:0] rbeat_data;
  logic          done, done_err, done_timeout;
  logic          p_wen, p_ren;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [3:0]    p_strobe;
  logic          p_error, p_request_stall;

  int checks   = 0;
  int failures = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int done_cnt  = 0;
  int d0;

  logic [31:0] wrap_exp [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
  logic [1:0]  bad_t [3] = '{2'b10, 2'b11, 2'b01};
  logic [31:0] bad_a [3] = '{32'h40, 32'h40, 32'h102};
  logic [7:0]  bad_l [3] = '{8'd2, 8'd0, 8'd1};

  bus_burst_engine #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_type        (req_type),
    .req_len         (req_len),
    .req_strobe      (req_strobe),
    .wbeat_valid     (wbeat_valid),
    .wbeat_data      (wbeat_data),
    .wbeat_ready     (wbeat_ready),
    .rbeat_valid     (rbeat_valid),
    .rbeat_data      (rbeat_data),
    .rbeat_last      (rbeat_last),
    .done            (done),
    .done_err        (done_err),
    .done_timeout    (done_timeout),
    .p_wen           (p_wen),
    .p_ren           (p_ren),
    .p_addr          (p_addr),
    .p_wdata         (p_wdata),
    .p_strobe        (p_strobe),
    .p_rdata         (p_rdata),
    .p_error         (p_error),
    .p_request_stall (p_request_stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wbeat_ready) wr_pulses++;
    if (rbeat_valid) rd_pulses++;
    if (done)        done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic w, input logic [31:0] a,
                         input logic [1:0] t, input logic [7:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_type  = t;
    req_len   = l;
    chk("req_ready_idle", req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk("check_no_access", {p_ren, p_wen}, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_type = 0;
    req_len = 0; req_strobe = 4'h5;
    wbeat_valid = 0; wbeat_data = 0;
    p_rdata = 0; p_error = 0; p_request_stall = 0;

    // reset state
    tick; tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outs", {p_ren, p_wen, done, rbeat_valid}, 0);
    chk("rst_addr", p_addr, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);

    // INCR read 0x100 len 3, no stall
    rd_pulses = 0;
    request(0, 32'h100, 2'b01, 8'd3);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("incr_ren", p_ren, 1);
      chk("incr_addr", p_addr, 32'h100 + 32'(4 * i));
      if (i > 0) begin
        chk("incr_rvalid", rbeat_valid, 1);
        chk("incr_rdata", rbeat_data, 32'hD0 + 32'(i - 1));
        chk("incr_rlast", rbeat_last, 0);
      end
      p_rdata = 32'hD0 + 32'(i);
    end
    tick;
    chk("incr_done", {done, done_err, done_timeout}, 3'b100);
    chk("incr_last_beat", {rbeat_valid, rbeat_last}, 2'b11);
    chk("incr_last_data", rbeat_data, 32'hD3);
    chk("incr_no_ren", p_ren, 0);
    tick;
    chk("incr_idle", {req_ready, done, rbeat_valid}, 3'b100);
    chk("incr_rbeats", rd_pulses, 4);

    // WRAP write 0x38 len 3 with gaps and a 5-cycle stall
    wr_pulses = 0;
    request(1, 32'h38, 2'b10, 8'd3);
    tick;
    for (int b = 0; b < 4; b++) begin
      wbeat_valid = 1'b0;
      #1;
      chk("wgap_wen", {p_wen, wbeat_ready}, 0);
      chk("wgap_addr", p_addr, wrap_exp[b]);
      tick;
      wbeat_valid = 1'b1;
      wbeat_data  = 32'hC0DE_0000 + 32'(b);
      if (b == 1) begin
        p_request_stall = 1'b1;
        repeat (5) begin
          #1;
          chk("wstall_wen", {p_wen, wbeat_ready}, 2'b10);
          chk("wstall_addr", p_addr, wrap_exp[b]);
          tick;
        end
        p_request_stall = 1'b0;
      end
      #1;
      chk("wbeat_ready", {p_wen, wbeat_ready}, 2'b11);
      chk("wbeat_addr", p_addr, wrap_exp[b]);
      chk("wbeat_data", p_wdata, 32'hC0DE_0000 + 32'(b));
      chk("wbeat_strobe", p_strobe, 4'h5);
      tick;
    end
    wbeat_valid = 1'b0;
    chk("wrap_done", {done, done_err}, 2'b10);
    chk("wrap_pulses", wr_pulses, 4);
    tick;

    // requests rejected in CHECK
    for (int k = 0; k < 3; k++) begin
      request(k == 1, bad_a[k], bad_t[k], bad_l[k]);
      tick;
      chk("bad_done", {done, done_err, done_timeout}, 3'b110);
      chk("bad_no_access", {p_ren, p_wen}, 0);
      tick;
      chk("bad_idle", {req_ready, done}, 2'b10);
    end

    // INCR read len 7, error on third beat
    rd_pulses = 0;
    request(0, 32'h200, 2'b01, 8'd7);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("perr_addr", p_addr, 32'h200 + 32'(4 * i));
      p_rdata = 32'hE0 + 32'(i);
      p_error = (i == 2);
    end
    tick;
    p_error = 1'b0;
    chk("perr_done", {done, done_err}, 2'b11);
    chk("perr_no_ren", p_ren, 0);
    chk("perr_rdata", {rbeat_valid, rbeat_data}, {1'b1, 32'hE2});
    tick;
    chk("perr_rbeats", rd_pulses, 3);
    chk("perr_idle", {p_ren, req_ready}, 2'b01);

    // long stall: watchdog aborts, or engine waits it out
    request(0, 32'h300, 2'b01, 8'd1);
    p_request_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("stall_hold", {p_ren, done, p_addr}, {2'b10, 32'h300});
    end
    tick;
`ifdef BURST_TIMEOUT_EN
    chk("tout_done", {done, done_err, done_timeout}, 3'b111);
    chk("tout_no_ren", p_ren, 0);
    p_request_stall = 1'b0;
    tick;
    chk("tout_idle", req_ready, 1);
`else
    chk("nowd_wait", {p_ren, done, p_addr}, {2'b10, 32'h300});
    p_request_stall = 1'b0;
    tick;
    chk("nowd_step", p_addr, 32'h304);
    tick;
    chk("nowd_done", {done, done_err, done_timeout}, 3'b100);
    tick;
`endif

    // reset in the middle of a burst
    request(0, 32'h400, 2'b01, 8'd3);
    tick;
    tick;
    chk("mid_addr", p_addr, 32'h404);
    d0 = done_cnt;
    rst = 1'b1;
    tick;
    chk("mid_rst_outs", {req_ready, p_ren, done, rbeat_valid}, 0);
    chk("mid_rst_addr", p_addr, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1);

    // SINGLE ignores len
    request(0, 32'h500, 2'b00, 8'd5);
    tick;
    chk("single_beat", {p_ren, p_addr}, {1'b1, 32'h500});
    p_rdata = 32'hF5;
    tick;
    chk("single_done", {done, done_err}, 2'b10);
    chk("single_rbeat", {rbeat_valid, rbeat_last, rbeat_data},
        {2'b11, 32'hF5});
    tick;
    chk("single_idle", {req_ready, p_ren}, 2'b10);
    chk("mid_rst_no_done", done_cnt, d0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
